// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the fetch/data memory bus arbiter.
package mem_bus_arbiter_pkg;

    localparam int unsigned BUS_W               = 32;
    localparam int unsigned MAX_DATA_STREAK_DEF = 4;
    localparam int unsigned TIMEOUT_DEF         = 255;
    localparam logic [BUS_W-1:0] NOP_INSTR_DEF  = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DREAD,
        S_DWRITE
    } bus_state_t;

endpackage

// File: rtl/bus_timeout_ctr.sv
// Wait-state watchdog: counts access cycles without ready and flags the cycle
// whose increment would reach TIMEOUT.
module bus_timeout_ctr #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clock,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [7:0] TC_VAL = 8'(TIMEOUT - 1);

    logic [7:0] count;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 8'd1;
        end
    end

    assign tc = en & (count == TC_VAL);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single memory bus between instruction fetch and load/store,
// with a data-streak limit against fetch starvation and a bus-hang watchdog.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned      MAX_DATA_STREAK = MAX_DATA_STREAK_DEF,
    parameter int unsigned      TIMEOUT         = TIMEOUT_DEF,
    parameter logic [BUS_W-1:0] NOP_INSTR       = NOP_INSTR_DEF
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             i_if_req,
    input  logic [BUS_W-1:0] i_if_addr,
    output logic [BUS_W-1:0] o_if_rdata,
    output logic             o_if_valid,
    input  logic             i_d_rd,
    input  logic             i_d_wr,
    input  logic [BUS_W-1:0] i_d_addr,
    input  logic [BUS_W-1:0] i_d_wdat,
    output logic [BUS_W-1:0] o_d_rdata,
    output logic             o_d_valid,
    output logic             o_bus_block,
    output logic [BUS_W-1:0] o_mem_addr,
    output logic [BUS_W-1:0] o_mem_wdat,
    output logic             o_mem_rd,
    output logic             o_mem_wr,
    input  logic [BUS_W-1:0] i_mem_rdat,
    input  logic             i_mem_ready,
    output logic             o_bus_err
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

    bus_state_t state;
    logic [3:0] streak;
    logic       data_req;
    logic       in_access;
    logic       tmo;

    assign data_req    = i_d_rd | i_d_wr;
    assign in_access   = (state != S_IDLE);
    assign o_bus_block = rst & data_req & ~o_d_valid;

    bus_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clock (clock),
        .rst   (rst),
        .clr   (~in_access),
        .en    (in_access & ~i_mem_ready),
        .tc    (tmo)
    );

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            streak     <= '0;
            o_if_rdata <= NOP_INSTR;
            o_if_valid <= 1'b0;
            o_d_rdata  <= '0;
            o_d_valid  <= 1'b0;
            o_mem_addr <= '0;
            o_mem_wdat <= '0;
            o_mem_rd   <= 1'b0;
            o_mem_wr   <= 1'b0;
            o_bus_err  <= 1'b0;
        end else begin
            o_if_valid <= 1'b0;
            o_d_valid  <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Data wins unless a pending fetch has already waited out the streak.
                    if (data_req && (!i_if_req || streak < STREAK_MAX)) begin
                        state      <= i_d_wr ? S_DWRITE : S_DREAD;
                        o_mem_rd   <= ~i_d_wr;
                        o_mem_wr   <= i_d_wr;
                        o_mem_addr <= i_d_addr;
                        o_mem_wdat <= i_d_wdat;
                        streak     <= i_if_req ? streak + 4'd1 : '0;
                    end else if (i_if_req) begin
                        state      <= S_FETCH;
                        o_mem_rd   <= 1'b1;
                        o_mem_addr <= i_if_addr;
                        o_mem_wdat <= '0;
                        streak     <= '0;
                    end
                end
                S_FETCH: begin
                    if (i_mem_ready || tmo) begin
                        o_if_rdata <= i_mem_ready ? i_mem_rdat : NOP_INSTR;
                        o_if_valid <= 1'b1;
                        o_bus_err  <= o_bus_err | ~i_mem_ready;
                        o_mem_rd   <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                S_DREAD: begin
                    if (i_mem_ready || tmo) begin
                        o_d_rdata <= i_mem_ready ? i_mem_rdat : '0;
                        o_d_valid <= 1'b1;
                        o_bus_err <= o_bus_err | ~i_mem_ready;
                        o_mem_rd  <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                S_DWRITE: begin
                    if (i_mem_ready || tmo) begin
                        o_d_valid <= 1'b1;
                        o_bus_err <= o_bus_err | ~i_mem_ready;
                        o_mem_wr  <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: inputs change and outputs are sampled
// 1 ns after each rising edge.
module tb_mem_bus_arbiter;

    logic        clock = 1'b0;
    logic        rst;
    logic        i_if_req;
    logic [31:0] i_if_addr;
    logic [31:0] o_if_rdata;
    logic        o_if_valid;
    logic        i_d_rd;
    logic        i_d_wr;
    logic [31:0] i_d_addr;
    logic [31:0] i_d_wdat;
    logic [31:0] o_d_rdata;
    logic        o_d_valid;
    logic        o_bus_block;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdat;
    logic        o_mem_rd;
    logic        o_mem_wr;
    logic [31:0] i_mem_rdat;
    logic        i_mem_ready;
    logic        o_bus_err;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    mem_bus_arbiter #(
        .MAX_DATA_STREAK (4),
        .TIMEOUT         (255),
        .NOP_INSTR       (32'h0000_0013)
    ) dut (
        .clock       (clock),
        .rst         (rst),
        .i_if_req    (i_if_req),
        .i_if_addr   (i_if_addr),
        .o_if_rdata  (o_if_rdata),
        .o_if_valid  (o_if_valid),
        .i_d_rd      (i_d_rd),
        .i_d_wr      (i_d_wr),
        .i_d_addr    (i_d_addr),
        .i_d_wdat    (i_d_wdat),
        .o_d_rdata   (o_d_rdata),
        .o_d_valid   (o_d_valid),
        .o_bus_block (o_bus_block),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdat  (o_mem_wdat),
        .o_mem_rd    (o_mem_rd),
        .o_mem_wr    (o_mem_wr),
        .i_mem_rdat  (i_mem_rdat),
        .i_mem_ready (i_mem_ready),
        .o_bus_err   (o_bus_err)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    logic [31:0] grants [10];
    logic [31:0] exp_g;
    int          ng;
    int          n;

    initial begin
        rst = 1'b0;
        i_if_req = 1'b0; i_if_addr = '0;
        i_d_rd = 1'b1; i_d_wr = 1'b0; i_d_addr = '0; i_d_wdat = '0;
        i_mem_rdat = '0; i_mem_ready = 1'b1;

        // Reset state
        tick(); tick();
        chk ("rst_if_rdata", o_if_rdata, 32'h0000_0013);
        chk1("rst_mem_rd",   o_mem_rd, 1'b0);
        chk1("rst_block",    o_bus_block, 1'b0);
        chk1("rst_bus_err",  o_bus_err, 1'b0);
        chk ("rst_d_rdata",  o_d_rdata, 32'h0);
        i_d_rd = 1'b0;
        rst = 1'b1;
        tick();

        // Lone fetch, ready tied high
        i_if_req = 1'b1; i_if_addr = 32'h100; i_mem_rdat = 32'h0050_0093;
        tick();
        chk1("f1_rd",     o_mem_rd, 1'b1);
        chk ("f1_addr",   o_mem_addr, 32'h100);
        chk1("f1_nvalid", o_if_valid, 1'b0);
        tick();
        chk1("f1_valid",  o_if_valid, 1'b1);
        chk ("f1_rdata",  o_if_rdata, 32'h0050_0093);
        chk1("f1_rd_off", o_mem_rd, 1'b0);
        i_if_req = 1'b0;
        tick();
        chk1("f1_pulse",  o_if_valid, 1'b0);
        chk1("f1_idle",   o_mem_rd, 1'b0);

        // Store with 3 wait states
        i_mem_ready = 1'b0;
        i_d_wr = 1'b1; i_d_addr = 32'h20; i_d_wdat = 32'hDEAD_BEEF;
        tick();
        i_d_addr = 32'h999; i_d_wdat = 32'h1234_5678;
        for (int k = 0; k < 4; k++) begin
            chk1("st_wr",     o_mem_wr, 1'b1);
            chk ("st_addr",   o_mem_addr, 32'h20);
            chk ("st_wdat",   o_mem_wdat, 32'hDEAD_BEEF);
            chk1("st_block",  o_bus_block, 1'b1);
            chk1("st_nvalid", o_d_valid, 1'b0);
            if (k == 3) i_mem_ready = 1'b1;
            tick();
        end
        chk1("st_valid",    o_d_valid, 1'b1);
        chk1("st_wr_off",   o_mem_wr, 1'b0);
        chk1("st_block_off", o_bus_block, 1'b0);
        chk ("st_no_rdata", o_d_rdata, 32'h0);
        i_d_wr = 1'b0;
        tick();
        chk1("st_pulse",    o_d_valid, 1'b0);
        chk1("st_block_0",  o_bus_block, 1'b0);

        // Simultaneous load and store: store wins
        i_d_rd = 1'b1; i_d_wr = 1'b1; i_d_addr = 32'h24;
        tick();
        chk1("rw_wr", o_mem_wr, 1'b1);
        chk1("rw_rd", o_mem_rd, 1'b0);
        tick();
        chk1("rw_valid", o_d_valid, 1'b1);
        chk ("rw_rdata", o_d_rdata, 32'h0);
        i_d_rd = 1'b0; i_d_wr = 1'b0;
        tick();

        // Fetch and load at the same edge: data first
        i_if_req = 1'b1; i_if_addr = 32'h200;
        i_d_rd = 1'b1; i_d_addr = 32'h40; i_mem_rdat = 32'h1111_1111;
        tick();
        chk1("fl_rd",    o_mem_rd, 1'b1);
        chk ("fl_addr",  o_mem_addr, 32'h40);
        chk1("fl_block", o_bus_block, 1'b1);
        tick();
        chk1("fl_dvalid", o_d_valid, 1'b1);
        chk1("fl_ivalid", o_if_valid, 1'b0);
        chk ("fl_drdata", o_d_rdata, 32'h1111_1111);
        i_d_rd = 1'b0; i_mem_rdat = 32'h2222_2222;
        tick();
        chk1("fl_frd",   o_mem_rd, 1'b1);
        chk ("fl_faddr", o_mem_addr, 32'h200);
        tick();
        chk1("fl_fvalid", o_if_valid, 1'b1);
        chk ("fl_frdata", o_if_rdata, 32'h2222_2222);
        i_if_req = 1'b0;
        tick();

        // Data streak limit with fetch pending
        i_if_req = 1'b1; i_if_addr = 32'h300;
        i_d_rd = 1'b1; i_d_addr = 32'h80;
        ng = 0;
        for (int c = 0; c < 24; c++) begin
            tick();
            if (o_mem_rd && ng < 10) begin
                grants[ng] = o_mem_addr;
                ng++;
            end
        end
        chk("sk_count", 32'(ng), 32'd10);
        for (int g = 0; g < 10; g++) begin
            exp_g = (g == 4 || g == 9) ? 32'h300 : 32'h80;
            if (g < ng) chk("sk_grant", grants[g], exp_g);
        end
        i_if_req = 1'b0; i_d_rd = 1'b0;
        tick(); tick(); tick();

        // Fetch timeout
        i_mem_ready = 1'b0;
        i_if_req = 1'b1; i_if_addr = 32'h400; i_mem_rdat = 32'hFFFF_FFFF;
        tick();
        n = 0;
        while (o_mem_rd && n < 300) begin
            n++;
            tick();
        end
        chk ("to_cycles", 32'(n), 32'd255);
        chk1("to_valid",  o_if_valid, 1'b1);
        chk ("to_nop",    o_if_rdata, 32'h0000_0013);
        chk1("to_err",    o_bus_err, 1'b1);
        chk1("to_rd_off", o_mem_rd, 1'b0);
        i_if_req = 1'b0; i_mem_ready = 1'b1;
        tick();
        i_d_rd = 1'b1; i_d_addr = 32'h44; i_mem_rdat = 32'h3333_3333;
        tick(); tick();
        chk1("to_ld_valid",  o_d_valid, 1'b1);
        chk ("to_ld_rdata",  o_d_rdata, 32'h3333_3333);
        chk1("to_err_stick", o_bus_err, 1'b1);
        i_d_rd = 1'b0;
        tick();

        // Reset during a DREAD wait state
        i_mem_ready = 1'b0;
        i_d_rd = 1'b1; i_d_addr = 32'h48;
        tick();
        chk1("rs_rd", o_mem_rd, 1'b1);
        tick(); tick();
        rst = 1'b0;
        #1;
        chk1("rs_rd_off", o_mem_rd, 1'b0);
        chk1("rs_block",  o_bus_block, 1'b0);
        chk1("rs_err",    o_bus_err, 1'b0);
        i_mem_ready = 1'b1;
        tick();
        chk1("rs_nvalid", o_d_valid, 1'b0);
        i_d_rd = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk1("rs_idle_valid", o_d_valid, 1'b0);
        i_if_req = 1'b1; i_if_addr = 32'h500; i_mem_rdat = 32'h4444_4444;
        tick();
        chk1("rs_frd",   o_mem_rd, 1'b1);
        chk ("rs_faddr", o_mem_addr, 32'h500);
        chk1("rs_err0",  o_bus_err, 1'b0);
        tick();
        chk1("rs_fvalid", o_if_valid, 1'b1);
        chk ("rs_frdata", o_if_rdata, 32'h4444_4444);
        i_if_req = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single external memory/IO bus between the CPU instruction-fetch port and the load/store data port.
- Sequences each bus transaction through a wait-state handshake (i_mem_ready) and stalls the CPU pipeline via o_bus_block while a data access is outstanding.
- Prevents fetch starvation with a data-streak limit.
- Turns a hung bus into a safe NOP fetch or zero load, and sets a sticky error flag.

Parameters:
- MAX_DATA_STREAK, 4, consecutive data grants allowed while a fetch is pending before fetch is forced (1..15).
- TIMEOUT, 255, cycles to wait for i_mem_ready before aborting (1..255, 8-bit counter).
- NOP_INSTR, 32'h00000013, instruction returned on an aborted fetch (addi x0,x0,0).

Ports:
- clock  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- i_if_req  in  1  fetch request, level, held until o_if_valid
- i_if_addr  in  32  fetch address
- o_if_rdata  out  32  fetched instruction
- o_if_valid  out  1  one-cycle fetch completion pulse
- i_d_rd  in  1  load request, level, held until o_d_valid
- i_d_wr  in  1  store request, level, held until o_d_valid
- i_d_addr  in  32  data address
- i_d_wdat  in  32  store data
- o_d_rdata  out  32  load data
- o_d_valid  out  1  one-cycle data completion pulse (loads and stores)
- o_bus_block  out  1  CPU stall while a data access is pending
- o_mem_addr  out  32  bus address
- o_mem_wdat  out  32  bus write data
- o_mem_rd  out  1  bus read strobe
- o_mem_wr  out  1  bus write strobe
- i_mem_rdat  in  32  bus read data
- i_mem_ready  in  1  bus completion for the current strobe
- o_bus_err  out  1  sticky timeout flag

Behaviour:
- Reset (rst low, asynchronous): state IDLE. All outputs 0 except o_if_rdata=NOP_INSTR. Streak and timeout counters 0. Strobes drop in the same instant; any in-flight transaction is discarded with no valid pulse.
- States: IDLE, FETCH, DREAD, DWRITE.
- IDLE grant, decided on the clock edge:
  - Data request present and (no fetch pending or streak<MAX_DATA_STREAK) -> DWRITE if i_d_wr, else DREAD; streak++ only if i_if_req=1.
  - Otherwise fetch request -> FETCH; streak cleared.
  - Neither -> stay IDLE.
  - i_d_wr and i_d_rd both high -> store wins; the load is not performed.
- Grant edge: registers o_mem_addr and o_mem_wdat from the granted port. Requester address/data changes after the grant are ignored.
- Access states: strobe o_mem_rd (FETCH/DREAD) or o_mem_wr (DWRITE) is a registered state decode. It stays asserted until the edge where i_mem_ready=1.
- Completion edge:
  - Capture i_mem_rdat into o_if_rdata or o_d_rdata (stores leave o_d_rdata unchanged).
  - Pulse the matching valid for exactly 1 cycle.
  - Return to IDLE.
  - Minimum transaction: request seen at edge N, strobe in cycle N..N+1, ready at edge N+1, valid high in cycle N+1..N+2.
  - No back-to-back grant without passing through IDLE.
  - Requester must drop its request in the valid cycle, or it is granted again.
- Timeout: 8-bit counter increments each access cycle without ready. When it reaches TIMEOUT:
  - Abort, drop the strobe, return to IDLE, set o_bus_err (cleared only by reset).
  - Fetch abort: o_if_rdata=NOP_INSTR, o_if_valid pulses.
  - Load abort: o_d_rdata=0, o_d_valid pulses.
  - Store abort: o_d_valid pulses, no write retry.
  - Counter clears on every grant.
- o_bus_block is combinational: rst & (i_d_rd|i_d_wr) & ~o_d_valid. It is 0 during reset and drops in the completion-pulse cycle.
- Streak saturates at MAX_DATA_STREAK and clears whenever the fetch queue is empty at a grant.

Decomposition:
- Shared package: state encoding, NOP_INSTR, default MAX_DATA_STREAK/TIMEOUT, bus-width constant 32.
- One natural sub-module, bus_timeout_ctr: load/clear, enable, terminal-count output.

Test Plan:
- Lone fetch, addr 0x00000100, ready tied 1 -> o_mem_rd one cycle with addr 0x100. Next cycle o_if_valid=1 with o_if_rdata = bus data 0x00500093.
- Store addr 0x20, wdat 0xDEADBEEF, ready after 3 wait cycles -> o_mem_wr held 4 cycles with addr/data stable, o_bus_block high throughout. o_d_valid pulses once, then o_bus_block=0.
- Fetch and load requested together at the same edge -> data granted first. Fetch granted on the next IDLE edge. o_d_valid precedes o_if_valid.
- Continuous data requests with fetch pending, MAX_DATA_STREAK=4 -> exactly 4 data transactions, then 1 fetch, then data resumes.
- i_mem_ready held 0 on a fetch -> abort after 255 cycles. o_if_rdata=0x00000013, o_if_valid pulse, o_bus_err=1 and still 1 after later good transactions.
- rst asserted in the middle of a DREAD wait state -> o_mem_rd=0 immediately, no o_d_valid pulse. After release, the next request starts from IDLE with o_bus_err=0.
